// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one iteration per cycle, 33-cycle latency.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_by_zero_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] bm_q, bm_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] sum33, rem33, diff33;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    bm_d      = bm_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_mag     = (op_i[0] && a_i[31]) ? (32'd0 - a_i) : a_i;
    b_mag     = (op_i[0] && b_i[31]) ? (32'd0 - b_i) : b_i;
    sum33     = '0;
    rem33     = '0;
    diff33    = '0;
    prod      = '0;
    quo       = '0;
    rem       = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          op_d      = op_i;
          neg_res_d = op_i[0] & (a_i[31] ^ b_i[31]);
          neg_rem_d = op_i[0] & a_i[31];
          if (op_i[1] && (b_i == 32'd0)) begin
            state_d = DONE;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            acc_d   = {32'd0, a_mag};
            bm_d    = b_mag;
          end
        end else begin
          state_d = IDLE;
          if (mthi_i) hi_d = a_i;
          if (mtlo_i) lo_d = a_i;
        end
      end
      RUN: begin
        if (!op_q[1]) begin
          sum33 = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, bm_q} : 33'd0);
          acc_d = {sum33, acc_q[31:1]};
        end else begin
          // Partial remainder lives in acc[63:32]; quotient bits shift into acc[0].
          rem33 = {acc_q[63:32], acc_q[31]};
          if (rem33 >= {1'b0, bm_q}) begin
            diff33 = rem33 - {1'b0, bm_q};
            acc_d  = {diff33[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d  = {rem33[31:0], acc_q[30:0], 1'b0};
          end
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (!op_q[1]) begin
          prod = neg_res_q ? (64'd0 - acc_q) : acc_q;
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else begin
          quo  = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
          rem  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
          lo_d = quo;
          hi_d = rem;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      bm_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      bm_q      <= bm_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o        = (state_q == RUN) || (state_q == FIX);
  assign done_o        = (state_q == DONE);
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency and control checks.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        mthi_i;
  logic        mtlo_i;
  logic        busy_o;
  logic        done_o;
  logic        div_by_zero_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .mthi_i(mthi_i), .mtlo_i(mtlo_i), .busy_o(busy_o), .done_o(done_o),
    .div_by_zero_o(div_by_zero_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation, then counts edges after E0 until done_o (bounded).
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done_o && lat < 100) begin
      if (busy_o) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    checks++; if (div_by_zero_o !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", div_by_zero_o); end
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 00000000", hi_o); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 00000000", lo_o); end
  endtask

  task automatic test_multu();
    int lat, bc;
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d exp 33", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d exp 33", bc); end
    checks++; if (hi_o !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", hi_o); end
    checks++; if (lo_o !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", lo_o); end
    checks++; if (div_by_zero_o !== 1'b0) begin errors++; $display("FAIL multu_dbz got %b exp 0", div_by_zero_o); end
    tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL multu_done_width got %b exp 0", done_o); end
  endtask

  task automatic test_mult();
    int lat, bc;
    do_op(2'b01, 32'hFFFFFFFD, 32'h00000007, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d exp 33", lat); end
    checks++; if (hi_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h exp ffffffeb", lo_o); end
    tick();
  endtask

  task automatic test_div();
    int lat, bc;
    do_op(2'b11, 32'hFFFFFFF9, 32'h00000002, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    checks++; if (lo_o !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo_o); end
    checks++; if (hi_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi_o); end
    tick();
    do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    checks++; if (lo_o !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", lo_o); end
    checks++; if (hi_o !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi got %h exp 00000000", hi_o); end
    checks++; if (div_by_zero_o !== 1'b0) begin errors++; $display("FAIL div_ovf_dbz got %b exp 0", div_by_zero_o); end
    tick();
  endtask

  task automatic test_div_zero();
    a_i = 32'h12345678; mthi_i = 1'b1;
    tick();
    mthi_i = 1'b0;
    checks++; if (hi_o !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", hi_o); end
    op_i = 2'b10; a_i = 32'd100; b_i = 32'd0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL dbz_done got %b exp 1", done_o); end
    checks++; if (div_by_zero_o !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b exp 1", div_by_zero_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL dbz_busy got %b exp 0", busy_o); end
    checks++; if (hi_o !== 32'h12345678) begin errors++; $display("FAIL dbz_hi got %h exp 12345678", hi_o); end
    checks++; if (lo_o !== 32'h80000000) begin errors++; $display("FAIL dbz_lo got %h exp 80000000", lo_o); end
    tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL dbz_done_clear got %b exp 0", done_o); end
    checks++; if (div_by_zero_o !== 1'b0) begin errors++; $display("FAIL dbz_flag_clear got %b exp 0", div_by_zero_o); end
  endtask

  task automatic test_ignore_start();
    int lat;
    op_i = 2'b10; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0; lat = 0;
    while (!done_o && lat < 100) begin
      if (lat == 5) begin
        op_i = 2'b00; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1; mtlo_i = 1'b1; mthi_i = 1'b1;
      end else begin
        start_i = 1'b0; mtlo_i = 1'b0; mthi_i = 1'b0;
      end
      if (lat == 10) begin
        checks++; if (lo_o !== 32'h80000000) begin errors++; $display("FAIL run_lo_stable got %h exp 80000000", lo_o); end
        checks++; if (hi_o !== 32'h12345678) begin errors++; $display("FAIL run_hi_stable got %h exp 12345678", hi_o); end
      end
      tick();
      lat++;
    end
    start_i = 1'b0; mtlo_i = 1'b0; mthi_i = 1'b0;
    checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_latency got %0d exp 33", lat); end
    checks++; if (lo_o !== 32'd14) begin errors++; $display("FAIL ignore_lo got %h exp 0000000e", lo_o); end
    checks++; if (hi_o !== 32'd2) begin errors++; $display("FAIL ignore_hi got %h exp 00000002", hi_o); end
    tick();
  endtask

  task automatic test_abandon();
    int lat, bc, dseen;
    op_i = 2'b10; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    dseen = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin op_i = 2'b00; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1; end
      else start_i = 1'b0;
      if (c == 10) reset = 1'b0;
      tick();
    end
    reset = 1'b1; start_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abandon_busy got %b exp 0", busy_o); end
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL abandon_hi got %h exp 00000000", hi_o); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL abandon_lo got %h exp 00000000", lo_o); end
    for (int c = 0; c < 40; c++) begin
      if (done_o) dseen++;
      tick();
    end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL abandon_no_done got %0d exp 0", dseen); end
    do_op(2'b10, 32'd100, 32'd7, lat, bc);
    checks++; if (lo_o !== 32'd14) begin errors++; $display("FAIL post_reset_lo got %h exp 0000000e", lo_o); end
    checks++; if (hi_o !== 32'd2) begin errors++; $display("FAIL post_reset_hi got %h exp 00000002", hi_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_op(2'b00, 32'd3, 32'd5, lat, bc);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b exp 1", done_o); end
    checks++; if (lo_o !== 32'd15) begin errors++; $display("FAIL b2b_first_lo got %h exp 0000000f", lo_o); end
    do_op(2'b00, 32'd6, 32'd7, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_second_latency got %0d exp 33", lat); end
    checks++; if (lo_o !== 32'd42) begin errors++; $display("FAIL b2b_second_lo got %h exp 0000002a", lo_o); end
    checks++; if (hi_o !== 32'd0) begin errors++; $display("FAIL b2b_second_hi got %h exp 00000000", hi_o); end
    tick();
  endtask

  task automatic test_move_priority();
    int lat, bc;
    a_i = 32'hCAFEF00D; mtlo_i = 1'b1;
    tick();
    checks++; if (lo_o !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo_lo got %h exp cafef00d", lo_o); end
    // start and mtlo together: the move must be dropped
    op_i = 2'b00; a_i = 32'd2; b_i = 32'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0; mtlo_i = 1'b0;
    checks++; if (lo_o !== 32'hCAFEF00D) begin errors++; $display("FAIL start_prio_lo got %h exp cafef00d", lo_o); end
    lat = 0;
    while (!done_o && lat < 100) begin tick(); lat++; end
    checks++; if (lo_o !== 32'd6) begin errors++; $display("FAIL start_prio_result got %h exp 00000006", lo_o); end
    tick();
  endtask

  initial begin
    reset = 1'b0; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0; mthi_i = 1'b0; mtlo_i = 1'b0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_abandon();
    test_back_to_back();
    test_move_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL have port start_i, input, 1 bit: request to begin the operation selected by op_i.
REQ-004 SHALL have port op_i, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have port a_i, input, 32 bits: multiplicand or dividend; also the write data for mthi_i and mtlo_i.
REQ-006 SHALL have port b_i, input, 32 bits: multiplier or divisor.
REQ-007 SHALL have port mthi_i, input, 1 bit: write a_i into HI.
REQ-008 SHALL have port mtlo_i, input, 1 bit: write a_i into LO.
REQ-009 SHALL have port busy_o, output, 1 bit: high while an operation is in RUN or FIX.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port div_by_zero_o, output, 1 bit: qualifies done_o for a divide with b_i = 0.
REQ-012 SHALL have port hi_o, output, 32 bits: HI register contents.
REQ-013 SHALL have port lo_o, output, 32 bits: LO register contents.

Function
REQ-014 SHALL implement four states: IDLE, RUN, FIX and DONE.
REQ-015 SHALL accept start_i only in IDLE or DONE, and SHALL capture op_i, a_i and b_i at that edge (E0).
- Operands are latched at E0, so later changes on a_i and b_i have no effect on the operation.
REQ-016 SHALL ignore start_i while in RUN or FIX: no restart and no change to the latched operands.
REQ-017 On an accepted start, SHALL go to RUN with the iteration counter at 0.
- For signed ops (MULT, DIV), operands are converted to magnitudes and the result signs are recorded.
REQ-018 In RUN, SHALL perform one iteration per cycle.
- Multiply: shift-add on the 32-bit magnitudes into a 64-bit accumulator.
- Divide: restoring shift-subtract.
- The counter increments each cycle; when the counter is 31, the next state is FIX (32 iterations, edges E1..E32).
REQ-019 In FIX (edge E33), SHALL apply the sign correction, write HI/LO and go to DONE.
- Multiply: {HI,LO} = 64-bit product (two's complement for MULT).
- Divide: LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
REQ-020 SHALL assert done_o only while in DONE, so done_o is visible for exactly the one cycle after E33 (33-cycle latency).
REQ-021 From DONE, SHALL go to IDLE on the next edge, or to RUN if start_i is high at that edge.
REQ-022 For DIVU or DIV with b_i = 0, SHALL go from IDLE or DONE straight to DONE at E0.
- done_o and div_by_zero_o are high for that one cycle.
- HI and LO are unchanged.
REQ-023 SHALL hold div_by_zero_o low in every cycle except such a DONE cycle.
REQ-024 For DIV 0x80000000 / 0xFFFFFFFF, SHALL produce LO = 0x80000000 and HI = 0x00000000, with no exception.
REQ-025 SHALL honour mthi_i and mtlo_i only in IDLE or DONE, and SHALL ignore them in RUN and FIX.
- If start_i is also high in the same cycle, start_i has priority and the move is dropped.
REQ-026 SHALL keep hi_o and lo_o stable between writes; the intermediate accumulator SHALL NOT be visible on hi_o or lo_o.

Reset
REQ-027 When reset is low at a rising edge, SHALL enter IDLE regardless of current state, abandoning any operation in progress.
REQ-028 During reset, SHALL clear the counter and internal accumulators, and SHALL clear HI and LO to 0x00000000.
REQ-029 In the cycle after reset, SHALL have busy_o = 0, done_o = 0 and div_by_zero_o = 0.
- No done pulse is ever produced for an abandoned operation.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy_o high for 33 cycles, done_o one cycle, HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-031 MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
REQ-032 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- Then DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
REQ-033 mthi_i with a_i = 0x12345678, then DIVU 100 / 0 -> done_o and div_by_zero_o both high in the cycle after E0, HI stays 0x12345678.
REQ-034 DIVU 100 / 7 started; start_i pulsed again with new operands at cycle 5; reset driven low at cycle 10 -> busy_o = 0 and HI = LO = 0 after that edge, no done_o.
- After reset, a new DIVU 100 / 7 gives LO = 14, HI = 2.
REQ-035 Back-to-back: start_i held high in the DONE cycle of a MULTU 3 x 5 -> LO = 15 on the first done_o.
- A second operation starts immediately and produces its own done_o 33 cycles later.
